// File: rtl/rob_id_allocator.sv
// Circular ROB ID allocator: offers the next ALLOC_W free IDs, frees the oldest on retire, and flushes.
// Optional occupancy/stall statistics are built when ROB_ALLOC_STATS_EN is defined.
module rob_id_allocator #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned ID_W    = 5,
  parameter int unsigned ALLOC_W = 4,
  parameter int unsigned RET_W   = 4,
  parameter int unsigned CNT_W   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              alloc_take,
  input  logic [2:0]              retire_cnt,
  input  logic                    flush,
  output logic [ALLOC_W*ID_W-1:0] rob_ids,
  output logic [ALLOC_W-1:0]      rob_ids_valid,
  output logic [CNT_W-1:0]        free_count,
  output logic [ID_W-1:0]         head_id,
  output logic                    empty,
  output logic                    full,
  output logic                    err,
  output logic [15:0]             stat_stall,
  output logic [CNT_W-1:0]        stat_peak
);

  localparam int unsigned STAT_W = 16;

  logic [ID_W-1:0]  head_q, head_d;
  logic [ID_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] take_req, take_lim, take_eff;
  logic [CNT_W-1:0] ret_req, ret_lim, ret_eff;
  logic             take_bad, ret_bad;

  // Clamp requests against pre-edge state; anything over the limit is a protocol error.
  always_comb begin
    free_cnt = CNT_W'(ENTRIES) - occ_q;
    take_req = CNT_W'(alloc_take);
    ret_req  = CNT_W'(retire_cnt);
    take_lim = (free_cnt < CNT_W'(ALLOC_W)) ? free_cnt : CNT_W'(ALLOC_W);
    ret_lim  = (occ_q < CNT_W'(RET_W)) ? occ_q : CNT_W'(RET_W);
    take_bad = take_req > take_lim;
    ret_bad  = ret_req > ret_lim;
    take_eff = take_bad ? take_lim : take_req;
    ret_eff  = ret_bad ? ret_lim : ret_req;
  end

  // Next state; flush discards everything outstanding and ignores take/retire.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    err_d  = err_q;
    if (flush) begin
      occ_d  = '0;
      head_d = tail_q;
    end else begin
      tail_d = tail_q + ID_W'(take_eff);
      head_d = head_q + ID_W'(ret_eff);
      occ_d  = occ_q + take_eff - ret_eff;
      err_d  = err_q | take_bad | ret_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    rob_ids       = '0;
    rob_ids_valid = '0;
    for (int i = 0; i < int'(ALLOC_W); i++) begin
      rob_ids[i*ID_W +: ID_W] = tail_q + ID_W'(i);
      rob_ids_valid[i]        = CNT_W'(i) < free_cnt;
    end
  end

  assign free_count = free_cnt;
  assign head_id    = head_q;
  assign empty      = occ_q == '0;
  assign full       = occ_q == CNT_W'(ENTRIES);
  assign err        = err_q;

`ifdef ROB_ALLOC_STATS_EN
  logic [STAT_W-1:0] stall_q;
  logic [CNT_W-1:0]  peak_q;

  // Stats survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      peak_q  <= '0;
    end else begin
      if (!flush && (free_cnt < CNT_W'(ALLOC_W)) && (stall_q != {STAT_W{1'b1}}))
        stall_q <= stall_q + STAT_W'(1);
      if (occ_d > peak_q)
        peak_q <= occ_d;
    end
  end

  assign stat_stall = stall_q;
  assign stat_peak  = peak_q;
`else
  assign stat_stall = '0;
  assign stat_peak  = '0;
`endif

endmodule

// File: doc/rob_id_allocator.md
Name: rob_id_allocator

Overview:
- Circular allocator for reorder-buffer entry IDs that feeds the rename/decode stage.
- Each cycle it offers the next ALLOC_W free ROB IDs in program order.
- The decoder consumes 0..ALLOC_W of them; commit returns 0..RET_W oldest IDs.
- It tracks head, tail and occupancy, and supports a full flush for misprediction recovery.

Parameters:
ENTRIES, 32, number of ROB entries; must be a power of two.
ID_W, 5, ROB ID width; equals log2(ENTRIES).
ALLOC_W, 4, IDs offered per cycle; equals decoder WIDTH.
RET_W, 4, maximum IDs retired per cycle.
CNT_W, 6, occupancy/free counter width; equals ID_W+1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
alloc_take  in  3  number of offered IDs consumed this cycle, lanes 0..alloc_take-1.
retire_cnt  in  3  number of oldest IDs freed by commit this cycle.
flush  in  1  discard all outstanding IDs.
rob_ids  out  ALLOC_W*ID_W  offered IDs; lane i = (tail+i) mod ENTRIES.
rob_ids_valid  out  ALLOC_W  lane i valid when i < free_count.
free_count  out  CNT_W  ENTRIES minus occupancy.
head_id  out  ID_W  oldest outstanding ID.
empty  out  1  occupancy == 0.
full  out  1  occupancy == ENTRIES.
err  out  1  sticky protocol-violation flag.
stat_stall  out  16  stall-cycle counter (optional feature).
stat_peak  out  CNT_W  peak occupancy (optional feature).

Behaviour:
- State registers: head[ID_W-1:0], tail[ID_W-1:0], occ[CNT_W-1:0], err.
- All outputs are decoded from registered state only; there is no combinational path from any input to any output.
- Asynchronous reset sets head=0, tail=0, occ=0, err=0, stats=0.
- Resulting output values after reset:
  - rob_ids lanes = 0,1,2,3.
  - rob_ids_valid=4'b1111, free_count=32, head_id=0, empty=1, full=0.
- Latency: a take or retire in cycle N is visible in outputs at cycle N+1.
- Effective counts:
  - take_eff = min(alloc_take, free_count, ALLOC_W).
  - ret_eff = min(retire_cnt, occ, RET_W).
  - Both use pre-edge state, so IDs allocated in cycle N cannot be retired in cycle N.
- Clamping: if alloc_take exceeds free_count or ALLOC_W, or retire_cnt exceeds occ or RET_W, the value is clamped and err is set to 1. err stays set until reset.
- Update, no flush:
  - tail += take_eff (mod ENTRIES).
  - head += ret_eff (mod ENTRIES).
  - occ = occ + take_eff - ret_eff.
- Flush has priority over take and retire:
  - occ=0, head=tail (old tail), tail unchanged.
  - alloc_take and retire_cnt are ignored that cycle and err is not evaluated.
- Wrap-around: pointers are modulo ENTRIES. Offered lanes wrap, e.g. tail=30 gives lanes 30,31,0,1.
- Full: occ==ENTRIES, rob_ids_valid=0, free_count=0, head==tail.
- Empty: occ==0, head==tail; full and empty are distinguished by occ, never by pointer compare.
- Simultaneous take and retire at full: take_eff is 0 (free_count is 0) while ret_eff applies, so no ID is double-issued.
- Reset asserted mid-operation: state returns to reset values immediately, independent of clk.

Optional Feature:
Macro ROB_ALLOC_STATS_EN.
- Defined:
  - stat_stall increments (saturating at 16'hFFFF) each cycle free_count < ALLOC_W and flush=0.
  - stat_peak holds the maximum occ ever reached.
  - Both clear on reset only; flush does not clear them.
- Undefined: the ports remain, tied to 0, and no counter logic is synthesized.

Test Plan:
- Reset, then hold idle -> rob_ids={0,1,2,3}, valid=4'b1111, free_count=32, empty=1, full=0, err=0.
- alloc_take=4 for 8 consecutive cycles -> full=1, free_count=0, valid=0, head_id=0. A further take=1 -> err=1, state unchanged.
- From occ=10 with tail=10, apply take=3 and retire=2 in the same cycle -> occ=11, tail=13, head_id=2, lanes {13,14,15,16}.
- Drive tail to 30 with occ=0 -> lanes {30,31,0,1}. take=4 -> tail=2, occ=4, head_id=30.
- occ=12, flush=1 together with take=4 and retire=4 -> occ=0, empty=1, head_id equals the old tail, tail unchanged, err=0.
- With ROB_ALLOC_STATS_EN: fill to 30 then retire 10 -> stat_peak=30. Each cycle with free_count<4 increments stat_stall. Without the macro both read 0.
